// File: rtl/prsnt_pwr_seq.sv
// Slot power sequencer: enables slot power on card insertion, waits for
// power-good, releases slot reset after a settle delay, and handles
// card removal, host power-down requests and power-good faults.
module prsnt_pwr_seq #(
  parameter logic [15:0] PGOOD_TMO = 16'd100,
  parameter logic [15:0] RST_DLY   = 16'd20,
  parameter logic [15:0] OFF_DLY   = 16'd5
) (
  input  logic       iCLK,
  input  logic       iRst_n,
  input  logic       iTick,
  input  logic       iPrsnt,
  input  logic       iPwrgd,
  input  logic       iForce_off,
  output logic       oPwr_en,
  output logic       oRst_n,
  output logic       oFault,
  output logic [2:0] oState,
  output logic       oPrsnt_chg
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_PG = 3'd1,
    ST_RST_DLY = 3'd2,
    ST_ON      = 3'd3,
    ST_PWR_OFF = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pwr_en_q;
  logic        rst_n_q;
  logic        fault_q;
  logic        prsnt_q;
  logic        prsnt_chg_q;
  logic        drop;

  assign drop = !iPrsnt | iForce_off;

  // Next-state decode; drop always takes priority over timeouts and power-good loss.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (iPrsnt && !iForce_off) state_d = ST_WAIT_PG;
      end
      ST_WAIT_PG: begin
        if (drop)                    state_d = ST_PWR_OFF;
        else if (iPwrgd)             state_d = ST_RST_DLY;
        else if (cnt_q == PGOOD_TMO) state_d = ST_FAULT;
      end
      ST_RST_DLY: begin
        if (drop)                    state_d = ST_PWR_OFF;
        else if (!iPwrgd)            state_d = ST_FAULT;
        else if (cnt_q == RST_DLY)   state_d = ST_ON;
      end
      ST_ON: begin
        if (drop)                    state_d = ST_PWR_OFF;
        else if (!iPwrgd)            state_d = ST_FAULT;
      end
      ST_PWR_OFF: begin
        if (cnt_q == OFF_DLY)        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!iPrsnt)                 state_d = ST_IDLE;
      end
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Tick counter restarts on every state change and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)                cnt_d = 16'd0;
    else if (iTick && cnt_q != 16'hFFFF)   cnt_d = cnt_q + 16'd1;
  end

  // State, counter and all outputs update together so outputs never lag the state.
  always_ff @(posedge iCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      pwr_en_q    <= 1'b0;
      rst_n_q     <= 1'b0;
      fault_q     <= 1'b0;
      prsnt_q     <= 1'b0;
      prsnt_chg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwr_en_q    <= (state_d == ST_WAIT_PG) || (state_d == ST_RST_DLY) ||
                     (state_d == ST_ON);
      rst_n_q     <= (state_d == ST_ON);
      fault_q     <= (state_d == ST_FAULT);
      prsnt_q     <= iPrsnt;
      prsnt_chg_q <= iPrsnt ^ prsnt_q;
    end
  end

  assign oPwr_en    = pwr_en_q;
  assign oRst_n     = rst_n_q;
  assign oFault     = fault_q;
  assign oState     = state_q;
  assign oPrsnt_chg = prsnt_chg_q;

endmodule

// File: tb/tb_prsnt_pwr_seq.sv
// Directed bench for prsnt_pwr_seq with short timing parameters and a
// tick strobe every fourth clock.
module tb_prsnt_pwr_seq;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       prsnt;
  logic       pwrgd;
  logic       force_off;
  logic       pwr_en;
  logic       slot_rst_n;
  logic       fault;
  logic [2:0] state;
  logic       chg;

  int errors = 0;
  int checks = 0;
  int tcnt   = 0;

  prsnt_pwr_seq #(
    .PGOOD_TMO(16'd4),
    .RST_DLY  (16'd3),
    .OFF_DLY  (16'd2)
  ) dut (
    .iCLK      (clk),
    .iRst_n    (rst_n),
    .iTick     (tick),
    .iPrsnt    (prsnt),
    .iPwrgd    (pwrgd),
    .iForce_off(force_off),
    .oPwr_en   (pwr_en),
    .oRst_n    (slot_rst_n),
    .oFault    (fault),
    .oState    (state),
    .oPrsnt_chg(chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick strobe: high for one full clock out of every four.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      tick = (tcnt % 4 == 0);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Advance until n ticks have been consumed by rising edges.
  task automatic wait_ticks(input int n);
    int k = 0;
    int guard = 0;
    logic was;
    while (k < n && guard < 200) begin
      was = tick;
      cyc();
      if (was) k++;
      guard++;
    end
    checks++;
    if (k < n) begin
      errors++;
      $error("FAIL wait_ticks: observed=%0d expected=%0d", k, n);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic pe,
                         input logic rn, input logic ft);
    chk({tag, ".state"},  {13'd0, state}, {13'd0, st});
    chk({tag, ".pwr_en"}, {15'd0, pwr_en}, {15'd0, pe});
    chk({tag, ".rst_n"},  {15'd0, slot_rst_n}, {15'd0, rn});
    chk({tag, ".fault"},  {15'd0, fault}, {15'd0, ft});
  endtask

  initial begin
    rst_n = 1'b1; prsnt = 1'b0; pwrgd = 1'b0; force_off = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.chg", {15'd0, chg}, 16'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk_out("idle", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("idle.chg", {15'd0, chg}, 16'd0);

    // Normal power-up: insert, power-good after 2 ticks, reset release 3 ticks later.
    prsnt = 1'b1;
    cyc();
    chk_out("insert", 3'd1, 1'b1, 1'b0, 1'b0);
    chk("insert.chg", {15'd0, chg}, 16'd1);
    cyc();
    chk("insert.chg_end", {15'd0, chg}, 16'd0);
    wait_ticks(2);
    chk_out("pg_wait", 3'd1, 1'b1, 1'b0, 1'b0);
    pwrgd = 1'b1;
    cyc();
    chk_out("pg_up", 3'd2, 1'b1, 1'b0, 1'b0);
    wait_ticks(3);
    chk_out("rst_hold", 3'd2, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_out("on", 3'd3, 1'b1, 1'b1, 1'b0);

    // Power-good loss while on.
    pwrgd = 1'b0;
    cyc();
    chk_out("pg_loss", 3'd5, 1'b0, 1'b0, 1'b1);
    prsnt = 1'b0;
    cyc();
    chk_out("fault_clr", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("fault_clr.chg", {15'd0, chg}, 16'd1);

    // Power-good timeout.
    prsnt = 1'b1;
    cyc();
    chk_out("tmo_start", 3'd1, 1'b1, 1'b0, 1'b0);
    wait_ticks(4);
    chk_out("tmo_edge", 3'd1, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_out("tmo_fault", 3'd5, 1'b0, 1'b0, 1'b1);
    force_off = 1'b1;
    cyc();
    chk_out("fault_force", 3'd5, 1'b0, 1'b0, 1'b1);
    force_off = 1'b0;
    prsnt = 1'b0;
    cyc();
    chk_out("tmo_remove", 3'd0, 1'b0, 1'b0, 1'b0);

    // Force-off holds IDLE even with a card present.
    prsnt = 1'b1; force_off = 1'b1;
    cyc();
    chk_out("idle_force", 3'd0, 1'b0, 1'b0, 1'b0);
    force_off = 1'b0;
    cyc();
    chk_out("idle_rearm", 3'd1, 1'b1, 1'b0, 1'b0);

    // Host force-off from ON, then automatic re-arm.
    pwrgd = 1'b1;
    cyc();
    chk_out("fo_rst", 3'd2, 1'b1, 1'b0, 1'b0);
    wait_ticks(3);
    cyc();
    chk_out("fo_on", 3'd3, 1'b1, 1'b1, 1'b0);
    force_off = 1'b1;
    cyc();
    chk_out("fo_off", 3'd4, 1'b0, 1'b0, 1'b0);
    force_off = 1'b0;
    wait_ticks(2);
    chk_out("fo_hold", 3'd4, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_out("fo_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_out("fo_rearm", 3'd1, 1'b1, 1'b0, 1'b0);

    // Simultaneous removal and power-good loss in RST_DLY: drop wins.
    cyc();
    chk_out("sim_rst", 3'd2, 1'b1, 1'b0, 1'b0);
    prsnt = 1'b0; pwrgd = 1'b0;
    cyc();
    chk_out("sim_drop", 3'd4, 1'b0, 1'b0, 1'b0);
    chk("sim_drop.chg", {15'd0, chg}, 16'd1);
    cyc();
    chk("sim_drop.chg_end", {15'd0, chg}, 16'd0);
    wait_ticks(2);
    cyc();
    chk_out("sim_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during WAIT_PG, then restart with card present.
    prsnt = 1'b1;
    cyc();
    cyc();
    chk_out("ar_wait", 3'd1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("ar_async.chg", {15'd0, chg}, 16'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk_out("ar_release", 3'd1, 1'b1, 1'b0, 1'b0);
    chk("ar_release.chg", {15'd0, chg}, 16'd1);
    cyc();
    chk("ar_release.chg_end", {15'd0, chg}, 16'd0);
    chk_out("ar_steady", 3'd1, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prsnt_pwr_seq.md
PRSNT_PWR_SEQ -- requirements
Module: prsnt_pwr_seq

Interface
REQ-001 SHALL have parameter PGOOD_TMO, default 16'd100: iTick count allowed for iPwrgd to rise after power enable.
REQ-002 SHALL have parameter RST_DLY, default 16'd20: iTick count from iPwrgd high to slot reset release.
REQ-003 SHALL have parameter OFF_DLY, default 16'd5: iTick count oPwr_en stays low before re-arming.
REQ-004 SHALL have iCLK, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have iRst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have iTick, input, 1: one-iCLK-wide timebase strobe, synchronous to iCLK.
REQ-007 SHALL have iPrsnt, input, 1: debounced slot present, high = card installed.
REQ-008 SHALL have iPwrgd, input, 1: slot power-good, high = good; synchronous to iCLK.
REQ-009 SHALL have iForce_off, input, 1: host request to power the slot down, level.
REQ-010 SHALL have oPwr_en, output, 1: slot power enable, high = on.
REQ-011 SHALL have oRst_n, output, 1: slot reset, low = held in reset.
REQ-012 SHALL have oFault, output, 1: high while in FAULT.
REQ-013 SHALL have oState, output, 3: current state encoding.
REQ-014 SHALL have oPrsnt_chg, output, 1: one-cycle pulse on any iPrsnt edge.

Function
REQ-015 SHALL implement states IDLE=0, WAIT_PG=1, RST_DLY=2, ON=3, PWR_OFF=4, FAULT=5; codes 6-7 SHALL return to IDLE on the next edge.
REQ-016 SHALL keep a 16-bit tick counter: cleared on every state change, +1 on iTick otherwise, saturating at 16'hFFFF.
REQ-017 Timed exit SHALL occur on the edge where counter == parameter; a parameter of 0 SHALL exit on the first edge after entry.
REQ-018 Define "drop" = !iPrsnt | iForce_off.
REQ-019 IDLE: iPrsnt & !iForce_off -> WAIT_PG; otherwise stay.
REQ-020 WAIT_PG: transitions in priority order: drop -> PWR_OFF; then iPwrgd -> RST_DLY; then counter == PGOOD_TMO -> FAULT.
REQ-021 RST_DLY: transitions in priority order: drop -> PWR_OFF; then !iPwrgd -> FAULT; then counter == RST_DLY -> ON.
REQ-022 ON: transitions in priority order: drop -> PWR_OFF; then !iPwrgd -> FAULT.
REQ-023 PWR_OFF: counter == OFF_DLY -> IDLE; drop and iPwrgd are ignored in this state.
REQ-024 FAULT: !iPrsnt -> IDLE; otherwise stay; iForce_off has no effect in this state.
REQ-025 oPwr_en SHALL be 1 in WAIT_PG, RST_DLY and ON; 0 in all other states.
REQ-026 oRst_n SHALL be 1 only in ON.
REQ-027 oFault SHALL be 1 only in FAULT.
REQ-028 All outputs SHALL be registered and SHALL change on the same edge as the state register; no combinational input-to-output path.
REQ-029 oPrsnt_chg SHALL be high for exactly one cycle, on the edge after iPrsnt differs from its registered copy.
REQ-030 On a simultaneous drop and timeout or power-good loss, drop SHALL win.

Reset
REQ-031 On iRst_n low, the block SHALL asynchronously set: state=IDLE, counter=0, oPwr_en=0, oRst_n=0, oFault=0, oPrsnt_chg=0, registered iPrsnt copy=0.
REQ-032 Reset asserted in any state SHALL drop oPwr_en immediately, without waiting for OFF_DLY.
REQ-033 A card present at reset release SHALL produce one oPrsnt_chg pulse, then enter WAIT_PG.

Verification
Bench parameters: PGOOD_TMO=4, RST_DLY=3, OFF_DLY=2; iTick every 4 cycles.
REQ-034 Insert card, raise iPwrgd after 2 ticks -> oPwr_en=1 on the edge after insertion; oRst_n=1 exactly 3 ticks after iPwrgd; oState=3.
REQ-035 Insert card, keep iPwrgd=0 -> FAULT after 4 ticks, oPwr_en=0, oFault=1; remove card -> IDLE, oFault=0.
REQ-036 In ON, drop iPwrgd -> FAULT on the next edge, oRst_n=0, oPwr_en=0.
REQ-037 In ON, pulse iForce_off -> PWR_OFF, oPwr_en=0 for 2 ticks, then IDLE, then WAIT_PG if iPrsnt is still 1 and iForce_off is 0.
REQ-038 In RST_DLY, remove card and drop iPwrgd on the same edge -> PWR_OFF, not FAULT; oPrsnt_chg=1 for one cycle.
REQ-039 Assert iRst_n mid-WAIT_PG -> all outputs take reset values asynchronously; after release with card present -> one oPrsnt_chg pulse, then WAIT_PG.
